// File: rtl/gals_pkg.sv
// gals_pkg: shared widths, read-FSM encodings and status codes for the GALS datapath
// Contents:
//   GALS_DATA_W  default word width between producers and display path
//   rd_state_t   read-side FSM states of rate_fifo_bridge
//   LED_*        status codes shared with the top-level control FSM
package gals_pkg;
   localparam int GALS_DATA_W = 16;
   typedef enum logic {RD_IDLE = 1'b0, RD_SHOW = 1'b1} rd_state_t;
   localparam logic [1:0] LED_RUN        = 2'd0;
   localparam logic [1:0] LED_WAIT       = 2'd1;
   localparam logic [1:0] LED_BUFF_EMPTY = 2'd2;
   localparam logic [1:0] LED_BUFF_FULL  = 2'd3;
endpackage

// File: rtl/tick_fifo_mem.sv
// tick_fifo_mem: DEPTH x DATA_W register array, one sync write port, one comb read port
// Ports:
//   clock    system clock
//   we       write enable
//   wr_addr  write address
//   wr_data  write word
//   rd_addr  read address
//   rd_data  read word (combinational)
// The array is deliberately not reset; contents are don't-care until written.
module tick_fifo_mem
   import gals_pkg::*;
#(
   parameter int DATA_W = GALS_DATA_W,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clock)
      if (we) mem[wr_addr] <= wr_data;
   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/rate_fifo_bridge.sv
// rate_fifo_bridge: single-clock tick-paced FIFO between producers (data_1) and display (data_2)
// Ports:
//   reset         async active-high reset
//   clock         system clock
//   wr_tick       producer-rate strobe
//   rd_tick       consumer-rate strobe
//   data_1_en     producer word valid
//   data_1        producer word
//   buffer_full   count == DEPTH
//   buffer_empty  count == 0
//   data_2_valid  data_2 holds a word popped at the last rd_tick
//   data_2        consumer word (registered)
//   count         current occupancy
//   drop_count    rejected writes while full (saturating)
// Build option: define RATE_FIFO_DROP_CNT_EN to build the drop counter; otherwise drop_count is 0.
module rate_fifo_bridge
   import gals_pkg::*;
#(
   parameter int DATA_W = GALS_DATA_W,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              reset,
   input  logic              clock,
   input  logic              wr_tick,
   input  logic              rd_tick,
   input  logic              data_1_en,
   input  logic [DATA_W-1:0] data_1,
   output logic              buffer_full,
   output logic              buffer_empty,
   output logic              data_2_valid,
   output logic [DATA_W-1:0] data_2,
   output logic [ADDR_W:0]   count,
   output logic [7:0]        drop_count
);
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en, rd_en;
   rd_state_t         state, state_nxt;
   assign buffer_full  = count == (ADDR_W+1)'(DEPTH);
   assign buffer_empty = count == '0;
   // A full FIFO rejects writes even when a pop frees a slot in the same cycle.
   assign wr_en = wr_tick && data_1_en && !buffer_full;
   assign rd_en = rd_tick && !buffer_empty;
   assign data_2_valid = state == RD_SHOW;
   tick_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clock   (clock),
      .we      (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (data_1),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         data_2 <= '0;
         state  <= RD_IDLE;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
            data_2 <= rd_data;
         end
         count <= (wr_en && !rd_en) ? count + 1'b1 :
                  (rd_en && !wr_en) ? count - 1'b1 : count;
         state <= state_nxt;
      end
   // Both states share the same transitions: a successful pop shows, an empty tick idles.
   always_comb begin
      state_nxt = state;
      if (rd_tick) state_nxt = rd_en ? RD_SHOW : RD_IDLE;
   end
`ifdef RATE_FIFO_DROP_CNT_EN
   always_ff @(posedge clock or posedge reset)
      if (reset) drop_count <= '0;
      else if (wr_tick && data_1_en && buffer_full && drop_count != 8'hFF)
         drop_count <= drop_count + 1'b1;
`else
   assign drop_count = 8'h00;
`endif
endmodule

// File: tb/tb_rate_fifo_bridge.sv
// tb_rate_fifo_bridge: directed scoreboard bench for rate_fifo_bridge
module tb_rate_fifo_bridge;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        wr_tick = 1'b0, rd_tick = 1'b0, data_1_en = 1'b0;
   logic [15:0] data_1 = '0;
   logic        buffer_full, buffer_empty, data_2_valid;
   logic [15:0] data_2;
   logic [3:0]  count;
   logic [7:0]  drop_count;
   int          total = 0, bad = 0;
   int          mcount = 0, mdrop = 0;
   logic        mvalid = 1'b0;
   logic [15:0] mdata = '0;
   logic [15:0] q[$];

   rate_fifo_bridge dut (
      .reset        (reset),
      .clock        (clock),
      .wr_tick      (wr_tick),
      .rd_tick      (rd_tick),
      .data_1_en    (data_1_en),
      .data_1       (data_1),
      .buffer_full  (buffer_full),
      .buffer_empty (buffer_empty),
      .data_2_valid (data_2_valid),
      .data_2       (data_2),
      .count        (count),
      .drop_count   (drop_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(mcount));
      chk({tag, ".empty"}, 32'(buffer_empty), 32'(mcount == 0));
      chk({tag, ".full"}, 32'(buffer_full), 32'(mcount == 8));
      chk({tag, ".valid"}, 32'(data_2_valid), 32'(mvalid));
      chk({tag, ".data_2"}, 32'(data_2), 32'(mdata));
      chk({tag, ".drop"}, 32'(drop_count), 32'(mdrop));
   endtask

   task automatic model_reset();
      q.delete();
      mcount = 0;
      mdrop  = 0;
      mvalid = 1'b0;
      mdata  = '0;
   endtask

   task automatic cyc(input string tag, input logic wt, input logic rt, input logic en,
                      input logic [15:0] d);
      logic wa, pa;
      pa = rt && mcount != 0;
      wa = wt && en && mcount != 8;
`ifdef RATE_FIFO_DROP_CNT_EN
      if (wt && en && mcount == 8 && mdrop != 255) mdrop++;
`endif
      if (pa) mdata = q.pop_front();
      if (rt) mvalid = pa;
      if (wa) q.push_back(d);
      mcount = mcount + int'(wa) - int'(pa);
      wr_tick = wt; rd_tick = rt; data_1_en = en; data_1 = d;
      @(posedge clock);
      #1;
      wr_tick = 1'b0; rd_tick = 1'b0; data_1_en = 1'b0;
      chk_all(tag);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk_all("reset");
      for (int i = 0; i < 3; i++) cyc("midfill", 1, 0, 1, 16'(10 + i));
      cyc("rd_to_show", 0, 1, 0, 0);
      reset = 1'b1;
      #2;
      model_reset();
      chk_all("async_reset");
      reset = 1'b0;
      cyc("tick_no_en", 1, 0, 0, 16'hDEAD);
      for (int i = 1; i <= 8; i++) cyc("fill", 1, 0, 1, 16'(i));
      cyc("reject9", 1, 0, 1, 16'd9);
      for (int i = 0; i < 9; i++) cyc("drain", 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) cyc("wrap_w5", 1, 0, 1, 16'(100 + i));
      for (int i = 0; i < 5; i++) cyc("wrap_p5", 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cyc("wrap_w6", 1, 0, 1, 16'(200 + i));
      for (int i = 0; i < 6; i++) cyc("wrap_p6", 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc("sim_fill4", 1, 0, 1, 16'(300 + i));
      cyc("sim_at4", 1, 1, 1, 16'd304);
      for (int i = 0; i < 4; i++) cyc("sim_fill8", 1, 0, 1, 16'(310 + i));
      cyc("sim_at8", 1, 1, 1, 16'd320);
      cyc("refill", 1, 0, 1, 16'd330);
      for (int i = 0; i < 300; i++) cyc("sat", 1, 0, 1, 16'(400 + i));
      for (int i = 0; i < 9; i++) cyc("final_drain", 0, 1, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
